// File: rtl/i2c_reg_access.sv
// rtl/i2c_reg_access.sv - register-level command sequencer in front of i2c_master
//
// Turns one host command (device, register, 1-4 data bytes, read/write) into
// i2c_master transactions: a write is one {reg, data} transfer; a read is a
// pointer write {reg} followed by an N-byte read packed into rdata.
//
// Ports:
//   c, rst_n                      clock, asynchronous active-low reset
//   cmd_req/we/dev/reg/len/wdata  host command (sampled only while idle)
//   cmd_busy, cmd_done, cmd_status, rdata   host status/results
//   m_req/addr/len/we/din         drive the attached i2c_master
//   m_din_ack, m_dout, m_dout_dv, m_ack, m_err   from the attached i2c_master
module i2c_reg_access #(
  parameter int LENWIDTH    = 4,
  parameter int TIMEOUT_CYC = 2500000
) (
  input  logic                c,
  input  logic                rst_n,
  input  logic                cmd_req,
  input  logic                cmd_we,
  input  logic [6:0]          cmd_dev,
  input  logic [7:0]          cmd_reg,
  input  logic [1:0]          cmd_len,
  input  logic [31:0]         cmd_wdata,
  output logic                cmd_busy,
  output logic                cmd_done,
  output logic [1:0]          cmd_status,
  output logic [31:0]         rdata,
  output logic                m_req,
  output logic [6:0]          m_addr,
  output logic [LENWIDTH-1:0] m_len,
  output logic                m_we,
  output logic [31:0]         m_din,
  input  logic                m_din_ack,
  input  logic [31:0]         m_dout,
  input  logic                m_dout_dv,
  input  logic                m_ack,
  input  logic                m_err
);

  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [2:0] {IDLE, PRE, XFER, POST, FIN} state_t;

  state_t        state, state_nx;
  logic          we_q;
  logic [6:0]    dev_q;
  logic [1:0]    len_q;
  logic [39:0]   tx_buf;
  logic          rd_phase;   // read command has finished its pointer write
  logic          err_used;   // a stale m_err level was already tolerated in PRE
  logic          din_acked;  // first data word taken by the master this transfer
  logic [TW-1:0] timer;
  logic [1:0]    status_q, status_nx;
  logic [31:0]   rdata_q;

  logic [2:0]    n_bytes;
  logic [31:0]   wdata_al;
  logic [31:0]   rd_mask;
  logic          pre_go;
  logic          err_live;
  logic          timeout;

  assign n_bytes  = {1'b0, len_q} + 3'd1;
  // Left-justify the N write bytes so the first byte follows the register byte.
  assign wdata_al = cmd_wdata << {2'd3 - cmd_len, 3'b000};
  assign rd_mask  = 32'hFFFF_FFFF >> {2'd3 - len_q, 3'b000};
  // A master still showing ERROR from the previous command clears it on req,
  // so one such level is let through; a second one means it is really stuck.
  assign pre_go   = !m_ack && (!m_err || !err_used);
  // The err level can be stale for the first two XFER cycles.
  assign err_live = m_err && (timer > TW'(1));
  assign timeout  = (timer == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      status_q <= 2'b00;
    end else begin
      state    <= state_nx;
      status_q <= status_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    status_nx = status_q;
    case (state)
      IDLE: if (cmd_req) state_nx = PRE;
      PRE:  if (pre_go) state_nx = XFER;
      XFER: begin
        if (err_live) begin
          state_nx  = FIN;
          status_nx = 2'b01;
        end else if (m_ack) begin
          state_nx = POST;
        end else if (timeout) begin
          state_nx  = FIN;
          status_nx = 2'b10;
        end
      end
      POST: begin
        if (!m_ack) begin
          if (!we_q && !rd_phase) begin
            state_nx = PRE;
          end else begin
            state_nx  = FIN;
            status_nx = 2'b00;
          end
        end
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      dev_q     <= 7'd0;
      len_q     <= 2'd0;
      tx_buf    <= 40'd0;
      rd_phase  <= 1'b0;
      err_used  <= 1'b0;
      din_acked <= 1'b0;
      timer     <= '0;
      rdata_q   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_req) begin
            we_q     <= cmd_we;
            dev_q    <= cmd_dev;
            len_q    <= cmd_len;
            tx_buf   <= cmd_we ? {cmd_reg, wdata_al} : {cmd_reg, 32'h0};
            rd_phase <= 1'b0;
            err_used <= 1'b0;
            rdata_q  <= 32'd0;
          end
        end
        PRE: begin
          if (pre_go) begin
            timer     <= '0;
            din_acked <= 1'b0;
            if (m_err) err_used <= 1'b1;
          end
        end
        XFER: begin
          if (timer != {TW{1'b1}}) timer <= timer + TW'(1);
          if (m_din_ack) din_acked <= 1'b1;
        end
        POST: begin
          if (!m_ack && !we_q && !rd_phase) rd_phase <= 1'b1;
        end
        default: ;
      endcase
      if (rd_phase && !we_q && m_dout_dv && (state == XFER || state == POST))
        rdata_q <= m_dout & rd_mask;
    end
  end

  always_comb begin
    m_req      = (state == XFER);
    cmd_busy   = (state == PRE) || (state == XFER) || (state == POST);
    cmd_done   = (state == FIN);
    cmd_status = status_q;
    rdata      = rdata_q;
    m_addr     = 7'd0;
    m_we       = 1'b0;
    m_len      = '0;
    m_din      = 32'd0;
    if (state != IDLE) begin
      m_addr = dev_q;
      m_we   = we_q | ~rd_phase;
      if (we_q)
        m_len = LENWIDTH'(n_bytes + 3'd1);
      else if (rd_phase)
        m_len = LENWIDTH'(n_bytes);
      else
        m_len = LENWIDTH'(1);
      m_din = din_acked ? {tx_buf[7:0], 24'h0} : tx_buf[39:8];
    end
  end

endmodule

// File: tb/tb_i2c_reg_access.sv
// tb/tb_i2c_reg_access.sv - bench for i2c_reg_access with a behavioural master
module tb_i2c_reg_access;

  localparam int TO = 40;

  logic        c = 1'b0;
  logic        rst_n;
  logic        cmd_req, cmd_we;
  logic [6:0]  cmd_dev;
  logic [7:0]  cmd_reg;
  logic [1:0]  cmd_len;
  logic [31:0] cmd_wdata;
  logic        cmd_busy, cmd_done;
  logic [1:0]  cmd_status;
  logic [31:0] rdata;
  logic        m_req, m_we;
  logic [6:0]  m_addr;
  logic [3:0]  m_len;
  logic [31:0] m_din;
  logic        m_din_ack, m_dout_dv, m_ack, m_err;
  logic [31:0] m_dout;

  i2c_reg_access #(.LENWIDTH(4), .TIMEOUT_CYC(TO)) dut (
    .c(c), .rst_n(rst_n),
    .cmd_req(cmd_req), .cmd_we(cmd_we), .cmd_dev(cmd_dev), .cmd_reg(cmd_reg),
    .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_status(cmd_status), .rdata(rdata),
    .m_req(m_req), .m_addr(m_addr), .m_len(m_len), .m_we(m_we), .m_din(m_din),
    .m_din_ack(m_din_ack), .m_dout(m_dout), .m_dout_dv(m_dout_dv),
    .m_ack(m_ack), .m_err(m_err)
  );

  always #5 c = ~c;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural master: mode 0 completes, 1 NACKs (err level), 2 never finishes.
  int          mode = 0;
  logic [31:0] cur_dout = 32'h0;
  int          t = 0, cur = 0, xn = 0, dack_cnt = 0;
  logic [3:0]  xf_len[4];
  logic [31:0] xf_din0[4], xf_din1[4];
  logic        xf_we[4];
  logic [6:0]  xf_addr[4];
  int          xf_cyc[4];

  always @(negedge c) begin
    m_din_ack = 1'b0;
    m_dout_dv = 1'b0;
    if (!rst_n) begin
      m_ack = 1'b0;
      m_err = 1'b0;
      t = 0;
    end else if (m_req) begin
      if (t == 0) begin
        cur = xn;
        xn++;
        if (cur < 4) begin
          xf_len[cur]  = m_len;
          xf_din0[cur] = m_din;
          xf_we[cur]   = m_we;
          xf_addr[cur] = m_addr;
        end
      end
      t++;
      if (cur < 4) xf_cyc[cur] = t;
      if (t == 3) m_err = 1'b0;
      if (mode == 0) begin
        if (m_we) begin
          if (t == 3 || (t == 6 && m_len == 4'd5)) begin
            m_din_ack = 1'b1;
            dack_cnt++;
          end
          if (t == 5 && cur < 4) xf_din1[cur] = m_din;
        end else begin
          if (t == 3) begin m_dout_dv = 1'b1; m_dout = 32'hFFFF_FFFF; end
          if (t == 5) begin m_dout_dv = 1'b1; m_dout = cur_dout; end
        end
        if (t == 8) m_ack = 1'b1;
      end else if (mode == 1 && t == 4) begin
        m_err = 1'b1;
      end
    end else begin
      t = 0;
      m_ack = 1'b0;
    end
  end

  typedef struct {
    logic        we;
    logic [6:0]  dev;
    logic [7:0]  rg;
    logic [1:0]  len;
    logic [31:0] wdata;
    int          mode;
    logic [31:0] dout;
    logic [1:0]  st;
    logic [31:0] rd;
    int          nx;
    logic [3:0]  len0;
    logic [31:0] din0;
    logic [31:0] din1;
    int          dacks;
  } vec_t;

  vec_t vecs[9];

  task automatic run_cmd(input vec_t v, input bit poke, input string tag);
    bit done_seen;
    done_seen = 1'b0;
    @(negedge c);
    mode = v.mode; cur_dout = v.dout; xn = 0; dack_cnt = 0;
    cmd_we = v.we; cmd_dev = v.dev; cmd_reg = v.rg; cmd_len = v.len; cmd_wdata = v.wdata;
    cmd_req = 1'b1;
    @(negedge c);
    cmd_req = 1'b0;
    chk({tag, " busy_after_accept"}, cmd_busy, 1'b1);
    for (int i = 0; i < 300 && !done_seen; i++) begin
      @(negedge c);
      if (poke && i == 3) begin cmd_req = 1'b1; cmd_dev = 7'h7F; cmd_we = ~v.we; end
      if (poke && i == 4) cmd_req = 1'b0;
      if (cmd_done) done_seen = 1'b1;
    end
    chk({tag, " done_seen"}, done_seen, 1'b1);
    chk({tag, " busy_at_done"}, cmd_busy, 1'b0);
    chk({tag, " status"}, cmd_status, v.st);
    chk({tag, " rdata"}, rdata, v.rd);
    chk({tag, " xfers"}, xn, v.nx);
    chk({tag, " x0_addr"}, xf_addr[0], v.dev);
    chk({tag, " x0_we"}, xf_we[0], 1'b1);
    chk({tag, " x0_len"}, xf_len[0], v.len0);
    chk({tag, " x0_din"}, xf_din0[0], v.din0);
    chk({tag, " din_acks"}, dack_cnt, v.dacks);
    if (v.nx == 2) begin
      chk({tag, " x1_we"}, xf_we[1], 1'b0);
      chk({tag, " x1_len"}, xf_len[1], {2'b00, v.len} + 4'd1);
      chk({tag, " x1_din"}, xf_din0[1], {v.rg, 24'h0});
    end
    if (v.len0 == 4'd5) chk({tag, " x0_din1"}, xf_din1[0], v.din1);
    if (v.mode == 2) chk({tag, " xfer_cycles"}, xf_cyc[0], TO);
    @(negedge c);
    chk({tag, " done_one_cycle"}, cmd_done, 1'b0);
    if (poke) begin
      @(negedge c);
      chk({tag, " no_second_cmd"}, {cmd_busy, m_req}, 2'b00);
    end
  endtask

  initial begin
    //          we  dev    reg    len  wdata          mode dout           st     rdata          nx len0 din0           din1          dacks
    vecs[0] = '{1'b1, 7'h48, 8'h10, 2'd1, 32'h0000ABCD, 0, 32'h0,         2'b00, 32'h0,         1, 4'd3, 32'h10ABCD00, 32'h0,         1};
    vecs[1] = '{1'b0, 7'h48, 8'h10, 2'd1, 32'h0,        0, 32'hDEADABCD,  2'b00, 32'h0000ABCD,  2, 4'd1, 32'h10000000, 32'h0,         1};
    vecs[2] = '{1'b1, 7'h48, 8'h10, 2'd3, 32'h11223344, 0, 32'h0,         2'b00, 32'h0,         1, 4'd5, 32'h10112233, 32'h44000000,  2};
    vecs[3] = '{1'b0, 7'h50, 8'h10, 2'd3, 32'h0,        1, 32'h0,         2'b01, 32'h0,         1, 4'd1, 32'h10000000, 32'h0,         0};
    vecs[4] = '{1'b1, 7'h20, 8'h7F, 2'd0, 32'hFFFFFF5A, 0, 32'h0,         2'b00, 32'h0,         1, 4'd2, 32'h7F5A0000, 32'h0,         1};
    vecs[5] = '{1'b0, 7'h21, 8'h01, 2'd0, 32'h0,        0, 32'h12345678,  2'b00, 32'h00000078,  2, 4'd1, 32'h01000000, 32'h0,         1};
    vecs[6] = '{1'b0, 7'h21, 8'h02, 2'd2, 32'h0,        0, 32'hAABBCCDD,  2'b00, 32'h00BBCCDD,  2, 4'd1, 32'h02000000, 32'h0,         1};
    vecs[7] = '{1'b1, 7'h33, 8'h05, 2'd0, 32'h000000C3, 2, 32'h0,         2'b10, 32'h0,         1, 4'd2, 32'h05C30000, 32'h0,         0};
    vecs[8] = '{1'b0, 7'h48, 8'h22, 2'd1, 32'h0,        0, 32'h00005A5A,  2'b00, 32'h00005A5A,  2, 4'd1, 32'h22000000, 32'h0,         1};

    rst_n = 1'b0; cmd_req = 1'b0; cmd_we = 1'b0; cmd_dev = 7'd0; cmd_reg = 8'd0;
    cmd_len = 2'd0; cmd_wdata = 32'd0;
    m_din_ack = 1'b0; m_dout = 32'd0; m_dout_dv = 1'b0; m_ack = 1'b0; m_err = 1'b0;
    #12;
    chk("reset_outputs",
        {cmd_busy, cmd_done, cmd_status, rdata, m_req, m_addr, m_len, m_we, m_din},
        '0);
    @(negedge c);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_cmd(vecs[i], (i == 0), $sformatf("v%0d", i));

    // Reset in the middle of the read data phase.
    @(negedge c);
    mode = 0; cur_dout = 32'h01020304; xn = 0; dack_cnt = 0;
    cmd_we = 1'b0; cmd_dev = 7'h48; cmd_reg = 8'h10; cmd_len = 2'd3; cmd_req = 1'b1;
    @(negedge c);
    cmd_req = 1'b0;
    for (int i = 0; i < 200 && !(xn == 2 && t >= 6); i++) @(negedge c);
    chk("rst_mid_reached", (xn == 2 && m_req), 1'b1);
    chk("rst_mid_rdata_nonzero", (rdata != 32'h0), 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_async", {m_req, cmd_busy, cmd_done, rdata}, '0);
    repeat (2) @(negedge c);
    chk("rst_mid_no_done", cmd_done, 1'b0);
    rst_n = 1'b1;
    run_cmd(vecs[1], 1'b0, "after_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
